mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_resp_pkg.sv | 28 ++
 rtl/mem_responder_mem_array.sv | 29 ++
 rtl/mem_responder.sv | 144 ++++++++++++++
 tb/tb_mem_responder.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_resp_pkg.sv
// Shared types and widths for the mem_responder slice: FSM encoding, bus widths
// and the access-error predicate used when MEM_ERR_CHECK_EN is defined.
package mem_resp_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned BE_W   = 4;
  localparam int unsigned BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // Misaligned word/halfword access, or any address beyond the 2^aw-word array.
  function automatic logic addr_err(input logic [ADDR_W-1:0] a,
                                    input logic [BE_W-1:0]   be,
                                    input int unsigned       aw);
    logic misalign;
    logic out_of_range;
    misalign     = ((be == 4'b1111) && (a[1:0] != 2'b00)) ||
                   (((be == 4'b0011) || (be == 4'b1100)) && a[0]);
    out_of_range = (a >> (aw + 2)) != '0;
    return misalign || out_of_range;
  endfunction

endpackage

// File: rtl/mem_responder_mem_array.sv
// mem_array: single-port word store with per-byte write enables, synchronous
// write and combinational read; one lane array per byte so lanes stay independent.
module mem_array
  import mem_resp_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [BE_W-1:0]   be_i,
  input  logic [AW-1:0]     addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  for (genvar gi = 0; gi < BE_W; gi++) begin : g_lane
    logic [BYTE_W-1:0] lane_q [DEPTH_WORDS];

    always_ff @(posedge clk_i) begin
      if (we_i && be_i[gi]) begin
        lane_q[addr_i] <= wdata_i[BYTE_W*gi +: BYTE_W];
      end
    end

    assign rdata_o[BYTE_W*gi +: BYTE_W] = lane_q[addr_i];
  end

endmodule

// File: rtl/mem_responder.sv
// mem_responder: fixed-latency memory slave (IDLE -> WAIT x WAIT_CYCLES -> RESP).
// Define MEM_ERR_CHECK_EN to flag misaligned / out-of-range accesses on err.
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [BE_W-1:0]   byte_en,
  output logic              ack,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              err
);

  localparam int unsigned AW        = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  WAIT_LOAD = 4'(WAIT_CYCLES);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [BE_W-1:0]   be_q;

  logic              capture;
  logic              commit;
  logic              cur_we;
  logic [ADDR_W-1:0] cur_addr;
  logic [DATA_W-1:0] cur_wdata;
  logic [BE_W-1:0]   cur_be;
  logic              cur_err;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
    end else if (capture) begin
      we_q    <= we;
      addr_q  <= addr;
      wdata_q <= wdata;
      be_q    <= byte_en;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          capture = 1'b1;
          if (WAIT_LOAD == 4'd0) begin
            state_d = RESP;
            commit  = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = WAIT_LOAD;
          end
        end
      end
      WAIT: begin
        if (cnt_q <= 4'd1) begin
          state_d = RESP;
          cnt_d   = '0;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: state_d = IDLE;
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // With no wait states the store commits on the capture edge, so the live inputs
  // are used in IDLE; every later cycle works from the captured copy.
  always_comb begin
    if (state_q == IDLE) begin
      cur_we    = we;
      cur_addr  = addr;
      cur_wdata = wdata;
      cur_be    = byte_en;
    end else begin
      cur_we    = we_q;
      cur_addr  = addr_q;
      cur_wdata = wdata_q;
      cur_be    = be_q;
    end
  end

`ifdef MEM_ERR_CHECK_EN
  assign cur_err = addr_err(cur_addr, cur_be, AW);
`else
  logic unused_addr_bits;
  assign cur_err          = 1'b0;
  assign unused_addr_bits = ^{cur_addr[ADDR_W-1:AW+2], cur_addr[1:0]};
`endif

  assign mem_we = commit && cur_we && !cur_err;

  mem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_mem (
    .clk_i  (clock),
    .we_i   (mem_we),
    .be_i   (cur_be),
    .addr_i (cur_addr[AW+1:2]),
    .wdata_i(cur_wdata),
    .rdata_o(mem_rdata)
  );

  assign ack   = (state_q == RESP);
  assign busy  = (state_q != IDLE);
  assign err   = ack && cur_err;
  assign rdata = (ack && !cur_we && !cur_err) ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed scenarios plus randomized
// traffic against a word-array reference model; a second instance runs zero-wait back-to-back.
module tb_mem_responder;

  localparam int DEPTH = 256;
  localparam int WAITC = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;

  logic        req = 1'b0, we = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [3:0]  byte_en = '0;
  logic        ack, busy, err;
  logic [31:0] rdata;

  logic        req0 = 1'b0, we0 = 1'b0;
  logic [31:0] addr0 = '0, wdata0 = '0;
  logic [3:0]  byte_en0 = '0;
  logic        ack0, busy0, err0;
  logic [31:0] rdata0;

  int compared = 0;
  int mismatched = 0;

  logic [31:0] ref_mem [DEPTH];

  always #5 clk = ~clk;

  mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAITC)) dut (
    .clock(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .byte_en(byte_en), .ack(ack), .rdata(rdata), .busy(busy), .err(err)
  );

  mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) dut0 (
    .clock(clk), .reset(reset), .req(req0), .we(we0), .addr(addr0), .wdata(wdata0),
    .byte_en(byte_en0), .ack(ack0), .rdata(rdata0), .busy(busy0), .err(err0)
  );

  // ---------------- reference model ----------------
  function automatic logic model_err(input logic [31:0] a, input logic [3:0] be);
`ifdef MEM_ERR_CHECK_EN
    if (a >= 32'(4 * DEPTH)) return 1'b1;
    if (be == 4'b1111 && (a % 4) != 0) return 1'b1;
    if ((be == 4'b0011 || be == 4'b1100) && (a % 2) != 0) return 1'b1;
    return 1'b0;
`else
    return (a != a); // always 0: without error checking nothing is ever flagged
`endif
  endfunction

  function automatic int model_idx(input logic [31:0] a);
    return int'((a / 4) % DEPTH);
  endfunction

  function automatic void model_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    int idx;
    idx = model_idx(a);
    for (int l = 0; l < 4; l++)
      if (be[l]) ref_mem[idx][8*l +: 8] = d[8*l +: 8];
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [3:0] be);
    if (model_err(a, be)) return 32'h0;
    return ref_mem[model_idx(a)];
  endfunction

  // ---------------- driver (no checking inside) ----------------
  task automatic run_txn(input logic t_we, input logic [31:0] t_addr, input logic [31:0] t_wd,
                         input logic [3:0] t_be, output int lat, output logic [31:0] rd,
                         output logic er, output int stray);
    lat = -1; rd = '0; er = 1'b0; stray = 0;
    req = 1'b1; we = t_we; addr = t_addr; wdata = t_wd; byte_en = t_be;
    @(posedge clk); #1;
    for (int c = 1; c <= 16 && lat < 0; c++) begin
      if (busy !== 1'b1) stray++;
      if (ack === 1'b1) begin
        lat = c; rd = rdata; er = err; req = 1'b0;
      end else begin
        if (rdata !== 32'h0) stray++;
        req = 1'($urandom); we = 1'($urandom); addr = $urandom;
        wdata = $urandom; byte_en = 4'($urandom);
      end
      @(posedge clk); #1;
    end
    req = 1'b0;
    if (busy !== 1'b0 || ack !== 1'b0 || rdata !== 32'h0) stray++;
    $display("txn we=%0b addr=%08h wdata=%08h be=%04b lat=%0d rdata=%08h err=%0b",
             t_we, t_addr, t_wd, t_be, lat, rd, er);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    compared++; if (ack !== 1'b0) begin mismatched++; $display("FAIL reset_ack got=%0b exp=0", ack); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    compared++; if (err !== 1'b0) begin mismatched++; $display("FAIL reset_err got=%0b exp=0", err); end
    compared++; if (rdata !== 32'h0) begin mismatched++; $display("FAIL reset_rdata got=%08h exp=0", rdata); end
    req = 1'b1; we = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL reset_hold_busy got=%0b exp=0", busy); end
    req = 1'b0; we = 1'b0;
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    int lat, stray; logic [31:0] rd; logic er;
    run_txn(1'b1, 32'h10, 32'hDEADBEEF, 4'b1111, lat, rd, er, stray);
    model_store(32'h10, 32'hDEADBEEF, 4'b1111);
    compared++; if (lat !== WAITC + 1) begin mismatched++; $display("FAIL store_latency got=%0d exp=%0d", lat, WAITC + 1); end
    compared++; if (er !== 1'b0) begin mismatched++; $display("FAIL store_err got=%0b exp=0", er); end
    compared++; if (rd !== 32'h0) begin mismatched++; $display("FAIL store_rdata got=%08h exp=0", rd); end
    compared++; if (stray !== 0) begin mismatched++; $display("FAIL store_busy_idle got=%0d exp=0", stray); end
    run_txn(1'b0, 32'h10, 32'h0, 4'b1111, lat, rd, er, stray);
    compared++; if (rd !== 32'hDEADBEEF) begin mismatched++; $display("FAIL load_word got=%08h exp=DEADBEEF", rd); end
    compared++; if (stray !== 0) begin mismatched++; $display("FAIL load_rdata_outside_ack got=%0d exp=0", stray); end
    run_txn(1'b1, 32'h10, 32'h000000AA, 4'b0001, lat, rd, er, stray);
    model_store(32'h10, 32'h000000AA, 4'b0001);
    run_txn(1'b0, 32'h10, 32'h0, 4'b1111, lat, rd, er, stray);
    compared++; if (rd !== 32'hDEADBEAA) begin mismatched++; $display("FAIL byte_lane_store got=%08h exp=DEADBEAA", rd); end
    run_txn(1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000, lat, rd, er, stray);
    compared++; if (lat !== WAITC + 1) begin mismatched++; $display("FAIL empty_be_ack got=%0d exp=%0d", lat, WAITC + 1); end
    run_txn(1'b0, 32'h10, 32'h0, 4'b1111, lat, rd, er, stray);
    compared++; if (rd !== 32'hDEADBEAA) begin mismatched++; $display("FAIL empty_be_nowrite got=%08h exp=DEADBEAA", rd); end
  endtask

  task automatic test_reset_abort();
    int lat, stray, seen_ack; logic [31:0] rd; logic er;
    run_txn(1'b1, 32'h20, 32'hCAFEF00D, 4'b1111, lat, rd, er, stray);
    model_store(32'h20, 32'hCAFEF00D, 4'b1111);
    req = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'h12345678; byte_en = 4'b1111;
    @(posedge clk); #1;
    req = 1'b0;
    compared++; if (busy !== 1'b1) begin mismatched++; $display("FAIL abort_busy_after_capture got=%0b exp=1", busy); end
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL abort_async_busy got=%0b exp=0", busy); end
    seen_ack = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (ack === 1'b1) seen_ack++;
    end
    reset = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (ack === 1'b1) seen_ack++;
    end
    compared++; if (seen_ack !== 0) begin mismatched++; $display("FAIL abort_no_ack got=%0d exp=0", seen_ack); end
    run_txn(1'b0, 32'h20, 32'h0, 4'b1111, lat, rd, er, stray);
    compared++; if (rd !== ref_mem[8]) begin mismatched++; $display("FAIL abort_no_write got=%08h exp=%08h", rd, ref_mem[8]); end
  endtask

  task automatic test_fill();
    int lat, stray; logic [31:0] rd, d; logic er;
    for (int i = 0; i < DEPTH; i++) begin
      d = $urandom;
      run_txn(1'b1, 32'(i * 4), d, 4'b1111, lat, rd, er, stray);
      model_store(32'(i * 4), d, 4'b1111);
      compared++; if (lat !== WAITC + 1) begin mismatched++; $display("FAIL fill_latency idx=%0d got=%0d exp=%0d", i, lat, WAITC + 1); end
    end
  endtask

  task automatic test_random();
    int lat, stray; logic [31:0] rd, t_addr, t_wd, exp_rd; logic er, t_we, exp_er; logic [3:0] t_be;
    for (int n = 0; n < 80; n++) begin
      t_we = 1'($urandom);
      t_wd = $urandom;
      if ($urandom_range(0, 9) == 0) t_addr = $urandom;
      else t_addr = 32'($urandom_range(0, 4 * DEPTH - 1));
      case ($urandom_range(0, 3))
        0: t_be = 4'b1111;
        1: t_be = 4'b0011;
        2: t_be = 4'b1100;
        default: t_be = 4'($urandom);
      endcase
      exp_er = model_err(t_addr, t_be);
      exp_rd = t_we ? 32'h0 : model_load(t_addr, t_be);
      run_txn(t_we, t_addr, t_wd, t_be, lat, rd, er, stray);
      if (t_we && !exp_er) model_store(t_addr, t_wd, t_be);
      compared++; if (lat !== WAITC + 1) begin mismatched++; $display("FAIL rand_latency n=%0d got=%0d exp=%0d", n, lat, WAITC + 1); end
      compared++; if (rd !== exp_rd) begin mismatched++; $display("FAIL rand_rdata n=%0d addr=%08h got=%08h exp=%08h", n, t_addr, rd, exp_rd); end
      compared++; if (er !== exp_er) begin mismatched++; $display("FAIL rand_err n=%0d addr=%08h got=%0b exp=%0b", n, t_addr, er, exp_er); end
      compared++; if (stray !== 0) begin mismatched++; $display("FAIL rand_outside_ack n=%0d got=%0d exp=0", n, stray); end
    end
  endtask

  task automatic test_errors();
    int lat, stray; logic [31:0] rd; logic er;
`ifdef MEM_ERR_CHECK_EN
    run_txn(1'b0, 32'h13, 32'h0, 4'b1111, lat, rd, er, stray);
    compared++; if (er !== 1'b1) begin mismatched++; $display("FAIL misaligned_err got=%0b exp=1", er); end
    compared++; if (rd !== 32'h0) begin mismatched++; $display("FAIL misaligned_rdata got=%08h exp=0", rd); end
    run_txn(1'b0, 32'h400, 32'h0, 4'b1111, lat, rd, er, stray);
    compared++; if (er !== 1'b1) begin mismatched++; $display("FAIL range_err got=%0b exp=1", er); end
    run_txn(1'b1, 32'h11, 32'hFFFFFFFF, 4'b0011, lat, rd, er, stray);
    compared++; if (er !== 1'b1) begin mismatched++; $display("FAIL half_misaligned_err got=%0b exp=1", er); end
    run_txn(1'b0, 32'h10, 32'h0, 4'b1111, lat, rd, er, stray);
    compared++; if (rd !== ref_mem[4]) begin mismatched++; $display("FAIL err_store_nowrite got=%08h exp=%08h", rd, ref_mem[4]); end
`else
    run_txn(1'b0, 32'h400, 32'h0, 4'b1111, lat, rd, er, stray);
    compared++; if (rd !== ref_mem[0]) begin mismatched++; $display("FAIL wrap_read got=%08h exp=%08h", rd, ref_mem[0]); end
    compared++; if (er !== 1'b0) begin mismatched++; $display("FAIL wrap_err got=%0b exp=0", er); end
    run_txn(1'b1, 32'h404, 32'h5A5AA5A5, 4'b1111, lat, rd, er, stray);
    model_store(32'h404, 32'h5A5AA5A5, 4'b1111);
    run_txn(1'b0, 32'h4, 32'h0, 4'b1111, lat, rd, er, stray);
    compared++; if (rd !== ref_mem[1]) begin mismatched++; $display("FAIL wrap_write got=%08h exp=%08h", rd, ref_mem[1]); end
`endif
  endtask

  task automatic test_back_to_back();
    logic [31:0] ref0 [4];
    logic        t_we [8];
    logic [31:0] t_addr [8];
    logic [31:0] t_wd [8];
    logic [31:0] exp_rd;
    int acks, stray;
    for (int i = 0; i < 4; i++) begin
      t_we[i] = 1'b1; t_addr[i] = 32'(i * 4); t_wd[i] = $urandom; ref0[i] = t_wd[i];
      t_we[4+i] = 1'b0; t_addr[4+i] = 32'((3 - i) * 4); t_wd[4+i] = $urandom;
    end
    acks = 0; stray = 0;
    @(posedge clk); #1;
    req0 = 1'b1; we0 = t_we[0]; addr0 = t_addr[0]; wdata0 = t_wd[0]; byte_en0 = 4'b1111;
    for (int c = 0; c < 24 && acks < 8; c++) begin
      @(posedge clk); #1;
      if (ack0 === 1'b1) begin
        exp_rd = t_we[acks] ? 32'h0 : ref0[int'(t_addr[acks] / 4)];
        compared++; if (c !== 2 * acks) begin mismatched++; $display("FAIL b2b_ack_cycle txn=%0d got=%0d exp=%0d", acks, c, 2 * acks); end
        compared++; if (rdata0 !== exp_rd) begin mismatched++; $display("FAIL b2b_rdata txn=%0d got=%08h exp=%08h", acks, rdata0, exp_rd); end
        compared++; if (busy0 !== 1'b1 || err0 !== 1'b0) begin mismatched++; $display("FAIL b2b_busy_err txn=%0d got=%0b/%0b exp=1/0", acks, busy0, err0); end
        $display("txn b2b we=%0b addr=%08h cycle=%0d rdata=%08h", t_we[acks], t_addr[acks], c, rdata0);
        acks++;
        if (acks < 8) begin
          we0 = t_we[acks]; addr0 = t_addr[acks]; wdata0 = t_wd[acks];
        end else begin
          req0 = 1'b0;
        end
      end else if (rdata0 !== 32'h0) begin
        stray++;
      end
    end
    req0 = 1'b0;
    compared++; if (acks !== 8) begin mismatched++; $display("FAIL b2b_ack_count got=%0d exp=8", acks); end
    compared++; if (stray !== 0) begin mismatched++; $display("FAIL b2b_rdata_outside_ack got=%0d exp=0", stray); end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_reset_abort();
    test_fill();
    test_random();
    test_errors();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
